// File: rtl/fanout_broadcast_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fanout_broadcast_pkg : shared sizing helpers for the broadcast FIFO slice
// Rev 1.0
// ----------------------------------------------------------------------------
package fanout_broadcast_pkg;

  // Pointer width: index bits plus one wrap flag.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH = 4;
  localparam int LEVEL_W       = ptr_w(DEFAULT_DEPTH);

  typedef logic [LEVEL_W-1:0] level_t;

  // LSB of lane 'lane' inside a packed vector of 'w'-bit lanes.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fanout_chan_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fanout_chan_fifo : one channel FIFO with wrap-flag pointers and flush
// Rev 1.0
// ----------------------------------------------------------------------------
module fanout_chan_fifo
  import fanout_broadcast_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rd_data = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q[IDX_W-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fanout_broadcast_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fanout_broadcast_fifo : broadcasts one source stream into NUM_LOADS FIFOs
// Rev 1.0
// ----------------------------------------------------------------------------
module fanout_broadcast_fifo
  import fanout_broadcast_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 3,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_LOADS-1:0]                     load_en,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         in_data,
  output logic [NUM_LOADS-1:0]                     out_valid,
  input  logic [NUM_LOADS-1:0]                     out_ready,
  output logic [NUM_LOADS*WIDTH-1:0]               out_data,
  output logic [NUM_LOADS*($clog2(DEPTH)+1)-1:0]   level,
  output logic [CNT_W-1:0]                         accept_cnt
);

  localparam int LVL_W = ptr_w(DEPTH);

  logic [NUM_LOADS-1:0] full;
  logic [NUM_LOADS-1:0] empty;
  logic                 accept;
  logic [CNT_W-1:0]     accept_cnt_q, accept_cnt_d;

  // Only enabled, full channels stall the source; out_ready is not involved.
  assign in_ready   = &(~(full & load_en));
  assign accept     = in_valid & in_ready;
  assign out_valid  = ~empty;
  assign accept_cnt = accept_cnt_q;

  generate
    for (genvar i = 0; i < NUM_LOADS; i++) begin : g_chan
      fanout_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .flush   (~load_en[i]),
        .push    (accept),
        .pop     (out_ready[i]),
        .wr_data (in_data),
        .full    (full[i]),
        .empty   (empty[i]),
        .rd_data (out_data[lane_lsb(i, WIDTH) +: WIDTH]),
        .level   (level[lane_lsb(i, LVL_W) +: LVL_W])
      );
    end
  endgenerate

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    if (accept) begin
      accept_cnt_d = accept_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_q <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fanout_broadcast_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fanout_broadcast_fifo : directed + random stimulus against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fanout_broadcast_fifo;

  localparam int WIDTH = 8;
  localparam int NL    = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NL-1:0]        load_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [NL-1:0]        out_valid;
  logic [NL-1:0]        out_ready;
  logic [NL*WIDTH-1:0]  out_data;
  logic [NL*LW-1:0]     level;
  logic [CNT_W-1:0]     accept_cnt;

  fanout_broadcast_fifo #(
    .WIDTH     (WIDTH),
    .NUM_LOADS (NL),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .accept_cnt (accept_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus a plain accepted-word count.
  logic [WIDTH-1:0] mq [NL][$];
  int unsigned      macc;
  logic             last_acc;
  int               pass_cnt = 0;
  int               total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic model_ready();
    logic r = 1'b1;
    for (int i = 0; i < NL; i++)
      if (load_en[i] && mq[i].size() == DEPTH) r = 1'b0;
    return r;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic mr;
    mr = model_ready();
    chk("in_ready", 32'(in_ready), 32'(mr));
    chk("accept_cnt", 32'(accept_cnt), 32'(macc[CNT_W-1:0]));
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
      chk($sformatf("level[%0d]", i), 32'(level[i*LW +: LW]), 32'(mq[i].size()));
      if (mq[i].size() > 0)
        chk($sformatf("out_data[%0d]", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(mq[i][0]));
    end
    last_acc = in_valid & mr;
    if (last_acc) macc++;
    for (int i = 0; i < NL; i++) begin
      if (!load_en[i]) begin
        mq[i].delete();
      end else begin
        if (out_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (last_acc) mq[i].push_back(in_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [NL-1:0] en, input logic v,
                       input logic [WIDTH-1:0] d, input logic [NL-1:0] ordy);
    load_en   = en;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    step();
  endtask

  int unsigned cnt0;
  int          sent;
  int          guard;

  initial begin
    rst = 1'b1; load_en = '0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    macc = 0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_cnt", 32'(accept_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic broadcast
    drive(3'b111, 1'b1, 8'h11, 3'b111);
    drive(3'b111, 1'b1, 8'h22, 3'b111);
    drive(3'b111, 1'b1, 8'h33, 3'b111);
    for (int k = 0; k < 3; k++) drive(3'b111, 1'b0, 8'h00, 3'b111);
    chk("basic_cnt", 32'(accept_cnt), 32'd3);

    // Back-pressure on channel 1
    sent = 0;
    for (int k = 0; k < 8; k++) begin
      drive(3'b111, sent < 6, 8'h40 + 8'(sent), 3'b101);
      if (last_acc) sent++;
    end
    chk("bp_sent", 32'(sent), 32'd4);
    chk("bp_level1", 32'(level[1*LW +: LW]), 32'd4);
    chk("bp_ready", 32'(in_ready), 32'd0);
    guard = 0;
    while (sent < 6 && guard < 20) begin
      drive(3'b111, 1'b1, 8'h40 + 8'(sent), 3'b111);
      if (last_acc) sent++;
      guard++;
    end
    chk("bp_resume", 32'(sent), 32'd6);
    for (int k = 0; k < 6; k++) drive(3'b111, 1'b0, 8'h00, 3'b111);

    // Wrap-around with continuous push/pop
    cnt0 = macc;
    for (int k = 0; k < 10; k++) drive(3'b111, 1'b1, 8'($urandom), 3'b111);
    drive(3'b111, 1'b0, 8'h00, 3'b111);
    chk("wrap_cnt", 32'(accept_cnt - CNT_W'(cnt0)), 32'd10);

    // Disable / flush channel 2
    for (int k = 0; k < 3; k++) drive(3'b111, 1'b1, 8'hA0 + 8'(k), 3'b011);
    drive(3'b011, 1'b0, 8'h00, 3'b011);
    chk("dis_valid2", 32'(out_valid[2]), 32'd0);
    chk("dis_level2", 32'(level[2*LW +: LW]), 32'd0);
    drive(3'b111, 1'b1, 8'h5A, 3'b011);
    chk("reen_valid2", 32'(out_valid[2]), 32'd1);
    chk("reen_data2", 32'(out_data[2*WIDTH +: WIDTH]), 32'h5A);
    drive(3'b111, 1'b0, 8'h00, 3'b111);
    drive(3'b111, 1'b0, 8'h00, 3'b111);

    // All channels disabled
    cnt0 = macc;
    for (int k = 0; k < 5; k++) drive(3'b000, 1'b1, 8'($urandom), 3'b111);
    chk("alloff_cnt", 32'(accept_cnt - CNT_W'(cnt0)), 32'd5);
    chk("alloff_valid", 32'(out_valid), 32'd0);

    // Randomised traffic
    load_en = 3'b111;
    for (int k = 0; k < 400; k++) begin
      logic [NL-1:0] en;
      en = load_en;
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, NL-1)] ^= 1'b1;
      drive(en, 1'($urandom), 8'($urandom), 3'($urandom));
    end

    // Asynchronous reset mid-operation
    drive(3'b111, 1'b1, 8'h77, 3'b000);
    drive(3'b111, 1'b1, 8'h78, 3'b000);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_cnt", 32'(accept_cnt), 32'd0);
    for (int i = 0; i < NL; i++) mq[i].delete();
    macc = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(3'b111, 1'b1, 8'hC3, 3'b000);
    chk("post_rst_valid", 32'(out_valid), 32'b111);
    chk("post_rst_data", 32'(out_data), 32'hC3C3C3);
    drive(3'b111, 1'b0, 8'h00, 3'b111);
    drive(3'b111, 1'b0, 8'h00, 3'b111);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fanout_broadcast_fifo.md
Name: fanout_broadcast_fifo

Overview:
- Parametrised broadcast stage that drives one source stream onto NUM_LOADS independent load channels.
- Each channel has its own DEPTH-entry FIFO, so a slow load never corrupts data for the others. Back-pressure from any enabled load stalls the source.
- Sits between a single driver domain and several hierarchical load groups. It is the registered successor to plain fanout buffering: it adds a per-channel enable/flush, flow control and an accepted-word counter.

Parameters:
- WIDTH, 8, data bits per word.
- NUM_LOADS, 3, number of output channels (at least 1).
- DEPTH, 4, entries per channel FIFO (a power of two, at least 2).
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  NUM_LOADS  per-channel enable. A channel whose bit is 0 is flushed and ignored.
- in_valid  in  1  source word valid.
- in_ready  out  1  source word accepted this cycle when in_valid is also 1.
- in_data  in  WIDTH  source word.
- out_valid  out  NUM_LOADS  channel i holds data.
- out_ready  in  NUM_LOADS  load i consumes its head word.
- out_data  out  NUM_LOADS*WIDTH  channel i head word, in bits [i*WIDTH +: WIDTH].
- level  out  NUM_LOADS*($clog2(DEPTH)+1)  occupancy of each channel.
- accept_cnt  out  CNT_W  count of accepted source words.

Behaviour:
- Reset (asynchronous, active-high):
  - All read/write pointers go to 0.
  - out_valid = 0, level = 0, accept_cnt = 0.
  - Storage contents are don't-care. out_data is don't-care while out_valid = 0.
- in_ready is the AND of !full[i] over every i with load_en[i] = 1.
  - It is combinational from registered state only. out_ready never feeds in_ready.
  - If no channel is enabled, in_ready = 1 and accepted words are discarded; accept_cnt still increments.
- Accept: a word is accepted when in_valid & in_ready are both 1 at a clock edge.
  - It is written into every enabled channel in the same edge.
  - A channel with load_en = 0 never receives the word.
- Latency: a word accepted at edge t is visible on out_valid/out_data of an empty channel after edge t. That is 1 cycle; there is no bypass path.
- Pop: channel i pops when out_valid[i] & out_ready[i] are both 1 at an edge. The head advances; the next word appears the following cycle.
- Pointers:
  - Each pointer is $clog2(DEPTH)+1 bits, with the top bit as the wrap flag.
  - empty when the pointers are equal; full when the low bits are equal and the wrap flags differ.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap flag.
- Simultaneous push and pop on a non-full, non-empty channel: level is unchanged and both pointers advance.
  - On a full channel a push is impossible, because in_ready = 0 even if the load pops in the same cycle.
  - On an empty channel, a pop is impossible because out_valid = 0.
- level[i] = wr_ptr - rd_ptr, in the range 0..DEPTH.
- Channel disable: while load_en[i] = 0, channel i's pointers are forced to 0 at every edge, so out_valid[i] = 0 from the next cycle.
  - Any pending words are lost.
  - A pop or push attempted in that cycle is ignored.
- Channel enable: a 0 to 1 transition starts the channel empty. It receives only words accepted at or after the first edge where load_en[i] = 1.
- accept_cnt increments by 1 per accepted word and wraps from 2^CNT_W-1 to 0 without saturating.
- No output is combinational from in_data.

Decomposition:
- Shared package fanout_broadcast_pkg holds:
  - the PTR_W = $clog2(DEPTH)+1 helper function;
  - a level-type localparam;
  - the lane-slice index helper for out_data and level packing.
- One sub-module, fanout_chan_fifo, holds one channel's storage, pointers, full/empty logic and flush input. The top instantiates NUM_LOADS copies in a generate loop.
- The top contains the in_ready reduction, accept decode and accept_cnt.

Test Plan:
- Basic broadcast:
  - Stimulus: WIDTH=8, NUM_LOADS=3, DEPTH=4, load_en=3'b111; push 0x11, 0x22, 0x33 with out_ready all 1.
  - Response: each channel emits 0x11, 0x22, 0x33 in order, each 1 cycle after acceptance; accept_cnt = 3.
- Back-pressure:
  - Stimulus: out_ready[1] = 0, others 1; push 6 words.
  - Response: in_ready drops after 4 accepted words; level[1] = 4; channels 0 and 2 drain all 4.
  - Follow-up: raise out_ready[1]. Response: words 5 and 6 are accepted once space frees.
- Wrap-around:
  - Stimulus: push and pop 10 words continuously on all channels.
  - Response: data order is preserved across pointer wrap; level never exceeds 1; accept_cnt = 10.
- Disable and flush:
  - Stimulus: fill channel 2 with 3 words, then drop load_en[2].
  - Response: out_valid[2] = 0 and level[2] = 0 the next cycle; in_ready now ignores channel 2.
  - Follow-up: re-enable channel 2 and push 0x5A. Response: channel 2 outputs only 0x5A.
- All channels disabled:
  - Stimulus: load_en = 0, in_valid = 1 for 5 cycles.
  - Response: in_ready = 1 throughout; accept_cnt = 5; no out_valid.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges while channels hold data.
  - Response: out_valid = 0, level = 0 and accept_cnt = 0 immediately, without waiting for a clock edge.
  - Follow-up: the first push after reset release appears on every enabled channel 1 cycle later.
